// File: rtl/uart_rffe_pkg.sv
// Shared constants, state enums and helpers for the UART-to-RFFE SPI bridge.
package uart_rffe_pkg;

  localparam logic [7:0] HDR_1  = 8'h55;
  localparam logic [7:0] HDR_2  = 8'h5D;
  localparam logic [7:0] TRL_CR = 8'h0D;
  localparam logic [7:0] TRL_LF = 8'h0A;

  localparam logic [7:0] CMD_SPI_WR = 8'h01;
  localparam logic [7:0] CMD_PING   = 8'hAA;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BADCMD = 8'h01;
  localparam logic [7:0] ST_BUSY   = 8'h03;

  typedef enum logic [3:0] {
    P_IDLE, P_HDR2, P_CMD, P_D0, P_D1, P_D2,
    P_D3, P_N, P_TAG, P_CR, P_LF
  } pstate_e;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_LE
  } spi_state_e;

  typedef enum logic {
    T_IDLE, T_SEND
  } tx_state_e;

  // N outside 1..4 means a full 32-bit word
  function automatic logic [5:0] spi_nbits(input logic [7:0] n);
    if (n == 8'd0 || n > 8'd4) return 6'd32;
    return {n[2:0], 3'b000};
  endfunction

  function automatic logic [7:0] ack_byte(
    input logic [2:0] idx,
    input logic [7:0] cmd,
    input logic [7:0] st,
    input logic [7:0] tag
  );
    case (idx)
      3'd0:    return HDR_1;
      3'd1:    return HDR_2;
      3'd2:    return cmd;
      3'd3:    return st;
      3'd4:    return tag;
      3'd5:    return TRL_CR;
      default: return TRL_LF;
    endcase
  endfunction

endpackage

// File: rtl/uart_rffe_bridge_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection,
// one-clock byte strobe and one-clock frame-error strobe.
module uart_rx
  import uart_rffe_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       ferr_o
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  sync_q;
  logic        rx_s;
  rx_state_e   st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  assign rx_s    = sync_q[1];
  assign byte_o  = sh_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      st_q    <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (st_q)
      R_IDLE: begin
        cnt_d = '0;
        if (!rx_s) st_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          st_d    = R_IDLE;
          valid_d = rx_s;
          ferr_d  = !rx_s;
        end
      end
      default: st_d = R_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rffe_bridge.sv
// UART command frames to 3-wire RFFE SPI writes; optional ack frame
// on FPGA_TX when UART_ACK_EN is defined (otherwise FPGA_TX is tied high).
module uart_rffe_bridge
  import uart_rffe_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned SPI_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       FPGA_RX,
  output logic       FPGA_TX,
  output logic       spi_clk_rffe,
  output logic       spi_sdo_rffe,
  output logic       spi_le_rffe,
  output logic [1:0] led
);

  localparam int unsigned CPB   = CLK_HZ / BAUD;
  localparam logic [15:0] DIV_M1 = 16'(SPI_DIV - 1);
  localparam logic [15:0] LE_M1  = 16'(2 * SPI_DIV - 1);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_i    (FPGA_RX),
    .byte_o  (rx_byte),
    .valid_o (rx_vld),
    .ferr_o  (rx_ferr)
  );

  pstate_e     pst_q, pst_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  n_q, n_d;
  logic        led0_q, led0_d;
  logic        exec;
`ifdef UART_ACK_EN
  logic [7:0]  tag_q, tag_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pst_q  <= P_IDLE;
      cmd_q  <= '0;
      dat_q  <= '0;
      n_q    <= '0;
      led0_q <= 1'b0;
`ifdef UART_ACK_EN
      tag_q  <= '0;
`endif
    end else begin
      pst_q  <= pst_d;
      cmd_q  <= cmd_d;
      dat_q  <= dat_d;
      n_q    <= n_d;
      led0_q <= led0_d;
`ifdef UART_ACK_EN
      tag_q  <= tag_d;
`endif
    end
  end

  always_comb begin
    pst_d  = pst_q;
    cmd_d  = cmd_q;
    dat_d  = dat_q;
    n_d    = n_q;
    led0_d = led0_q;
    exec   = 1'b0;
`ifdef UART_ACK_EN
    tag_d  = tag_q;
`endif
    if (rx_ferr) begin
      pst_d = P_IDLE;
    end else if (rx_vld) begin
      unique case (pst_q)
        P_IDLE: if (rx_byte == HDR_1) pst_d = P_HDR2;
        P_HDR2: begin
          if (rx_byte == HDR_2)      pst_d = P_CMD;
          else if (rx_byte != HDR_1) pst_d = P_IDLE;
        end
        P_CMD: begin cmd_d = rx_byte; pst_d = P_D0; end
        P_D0: begin dat_d[31:24] = rx_byte; pst_d = P_D1; end
        P_D1: begin dat_d[23:16] = rx_byte; pst_d = P_D2; end
        P_D2: begin dat_d[15:8] = rx_byte; pst_d = P_D3; end
        P_D3: begin dat_d[7:0] = rx_byte; pst_d = P_N; end
        P_N: begin n_d = rx_byte; pst_d = P_TAG; end
        P_TAG: begin
`ifdef UART_ACK_EN
          tag_d = rx_byte;
`endif
          pst_d = P_CR;
        end
        P_CR: pst_d = (rx_byte == TRL_CR) ? P_LF : P_IDLE;
        P_LF: begin
          pst_d = P_IDLE;
          if (rx_byte == TRL_LF) begin
            exec   = 1'b1;
            led0_d = !led0_q;
          end
        end
        default: pst_d = P_IDLE;
      endcase
    end
  end

  spi_state_e  sst_q, sst_d;
  logic [31:0] sh_q, sh_d;
  logic [5:0]  bits_q, bits_d;
  logic [15:0] div_q, div_d;
  logic        sck_q, sck_d;
  logic        sdo_q, sdo_d;
  logic        le_q, le_d;
  logic        spi_busy;
  logic        spi_go;

  assign spi_busy = (sst_q != S_IDLE);
  assign spi_go   = exec && (cmd_q == CMD_SPI_WR) && !spi_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sst_q  <= S_IDLE;
      sh_q   <= '0;
      bits_q <= '0;
      div_q  <= '0;
      sck_q  <= 1'b0;
      sdo_q  <= 1'b0;
      le_q   <= 1'b0;
    end else begin
      sst_q  <= sst_d;
      sh_q   <= sh_d;
      bits_q <= bits_d;
      div_q  <= div_d;
      sck_q  <= sck_d;
      sdo_q  <= sdo_d;
      le_q   <= le_d;
    end
  end

  // D0 sits in the MSB byte, so shifting from bit 31 sends D0 first
  always_comb begin
    sst_d  = sst_q;
    sh_d   = sh_q;
    bits_d = bits_q;
    div_d  = div_q + 16'd1;
    sck_d  = sck_q;
    sdo_d  = sdo_q;
    le_d   = le_q;
    unique case (sst_q)
      S_IDLE: begin
        div_d = '0;
        if (spi_go) begin
          sst_d  = S_SHIFT;
          sh_d   = dat_q;
          sdo_d  = dat_q[31];
          bits_d = spi_nbits(n_q);
          sck_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_M1) begin
          div_d = '0;
          sck_d = !sck_q;
          if (sck_q) begin
            sh_d   = {sh_q[30:0], 1'b0};
            bits_d = bits_q - 6'd1;
            if (bits_q == 6'd1) begin
              sst_d = S_LE;
              sdo_d = 1'b0;
              le_d  = 1'b1;
            end else begin
              sdo_d = sh_q[30];
            end
          end
        end
      end
      S_LE: begin
        if (div_q == LE_M1) begin
          div_d = '0;
          le_d  = 1'b0;
          sst_d = S_IDLE;
        end
      end
      default: sst_d = S_IDLE;
    endcase
  end

  assign spi_clk_rffe = sck_q;
  assign spi_sdo_rffe = sdo_q;
  assign spi_le_rffe  = le_q;
  assign led          = {spi_busy, led0_q};

`ifdef UART_ACK_EN
  localparam logic [15:0] CPB_M1 = 16'(CPB - 1);

  tx_state_e   tst_q, tst_d;
  logic [2:0]  tidx_q, tidx_d;
  logic [3:0]  tbit_q, tbit_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [9:0]  tsh_q, tsh_d;
  logic [7:0]  txc_q, txc_d;
  logic [7:0]  txs_q, txs_d;
  logic [7:0]  txt_q, txt_d;
  logic [7:0]  dtag_q, dtag_d;
  logic        pend_q, pend_d;
  logic        ack_now;
  logic        spi_done;
  logic [7:0]  ack_st;
  logic [2:0]  nidx;

  assign spi_done = (sst_q == S_LE) && (div_q == LE_M1);
  assign ack_now  = exec && !spi_go;
  assign nidx     = tidx_q + 3'd1;

  always_comb begin
    unique case (1'b1)
      cmd_q == CMD_SPI_WR: ack_st = ST_BUSY;
      cmd_q == CMD_PING:   ack_st = ST_OK;
      default:             ack_st = ST_BADCMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tst_q  <= T_IDLE;
      tidx_q <= '0;
      tbit_q <= '0;
      tcnt_q <= '0;
      tsh_q  <= '1;
      txc_q  <= '0;
      txs_q  <= '0;
      txt_q  <= '0;
      dtag_q <= '0;
      pend_q <= 1'b0;
    end else begin
      tst_q  <= tst_d;
      tidx_q <= tidx_d;
      tbit_q <= tbit_d;
      tcnt_q <= tcnt_d;
      tsh_q  <= tsh_d;
      txc_q  <= txc_d;
      txs_q  <= txs_d;
      txt_q  <= txt_d;
      dtag_q <= dtag_d;
      pend_q <= pend_d;
    end
  end

  // The write ack waits for the end of the LE pulse
  always_comb begin
    tst_d  = tst_q;
    tidx_d = tidx_q;
    tbit_d = tbit_q;
    tcnt_d = (tst_q == T_SEND) ? tcnt_q + 16'd1 : '0;
    tsh_d  = tsh_q;
    txc_d  = txc_q;
    txs_d  = txs_q;
    txt_d  = txt_q;
    dtag_d = dtag_q;
    pend_d = pend_q;
    if (spi_go) begin
      pend_d = 1'b1;
      dtag_d = tag_q;
    end else if (spi_done) begin
      pend_d = 1'b0;
    end
    if (ack_now || (spi_done && pend_q)) begin
      txc_d  = ack_now ? cmd_q : CMD_SPI_WR;
      txs_d  = ack_now ? ack_st : ST_OK;
      txt_d  = ack_now ? tag_q : dtag_q;
      tst_d  = T_SEND;
      tidx_d = '0;
      tbit_d = '0;
      tcnt_d = '0;
      tsh_d  = {1'b1, HDR_1, 1'b0};
    end else if (tst_q == T_SEND && tcnt_q == CPB_M1) begin
      tcnt_d = '0;
      if (tbit_q == 4'd9) begin
        tbit_d = '0;
        if (tidx_q == 3'd6) begin
          tst_d = T_IDLE;
          tsh_d = '1;
        end else begin
          tidx_d = nidx;
          tsh_d  = {1'b1, ack_byte(nidx, txc_q, txs_q, txt_q), 1'b0};
        end
      end else begin
        tbit_d = tbit_q + 4'd1;
        tsh_d  = {1'b1, tsh_q[9:1]};
      end
    end
  end

  assign FPGA_TX = tsh_q[0];
`else
  assign FPGA_TX = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rffe_bridge.sv
// Scoreboard bench for uart_rffe_bridge: SPI words and ack bytes are
// predicted when frames are sent and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_uart_rffe_bridge;

  localparam int CLK_HZ  = 50_000_000;
  localparam int BAUD    = 2_500_000;
  localparam int SPI_DIV = 25;
  localparam int BIT_NS  = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       FPGA_RX = 1'b1;
  logic       FPGA_TX;
  logic       spi_clk_rffe;
  logic       spi_sdo_rffe;
  logic       spi_le_rffe;
  logic [1:0] led;

  always #10 clk = ~clk;

  uart_rffe_bridge #(
    .CLK_HZ  (CLK_HZ),
    .BAUD    (BAUD),
    .SPI_DIV (SPI_DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .FPGA_RX      (FPGA_RX),
    .FPGA_TX      (FPGA_TX),
    .spi_clk_rffe (spi_clk_rffe),
    .spi_sdo_rffe (spi_sdo_rffe),
    .spi_le_rffe  (spi_le_rffe),
    .led          (led)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] w;
    int          n;
  } spi_exp_t;

  spi_exp_t   spi_q[$];
  logic [7:0] ack_q[$];
  logic       exp_led0 = 1'b0;

  logic [31:0] cap = '0;
  int          cap_n = 0;
  int          sck_rises = 0;
  time         t_le = 0;

  always @(posedge spi_clk_rffe or posedge spi_le_rffe or negedge rst_n)
  begin : spi_mon
    spi_exp_t e;
    if (!rst_n) begin
      cap   = '0;
      cap_n = 0;
    end else if (spi_clk_rffe) begin
      cap = {cap[30:0], spi_sdo_rffe};
      cap_n++;
      sck_rises++;
    end else if (spi_le_rffe) begin
      t_le = $time;
      if (spi_q.size() == 0) begin
        check("spi_unexpected", spi_q.size(), 1);
      end else begin
        e = spi_q.pop_front();
        check("spi_nbits", cap_n, e.n);
        check("spi_word", cap, e.w);
      end
      cap   = '0;
      cap_n = 0;
    end
  end

  always @(negedge spi_le_rffe)
    if (rst_n) check("le_width_ns", 32'($time - t_le), 1000);

`ifdef UART_ACK_EN
  initial begin : ack_mon
    logic [7:0] b;
    forever begin
      @(negedge FPGA_TX);
      #(BIT_NS / 2);
      for (int i = 0; i < 8; i++) begin
        #(BIT_NS);
        b[i] = FPGA_TX;
      end
      #(BIT_NS);
      check("ack_stop", FPGA_TX, 1);
      if (ack_q.size() == 0) check("ack_unexpected", ack_q.size(), 1);
      else check("ack_byte", b, ack_q.pop_front());
    end
  end
`else
  int tx_low_n = 0;
  always @(negedge FPGA_TX) if (rst_n) tx_low_n++;
`endif

  task automatic send_byte(input logic [7:0] b);
    FPGA_RX = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      FPGA_RX = b[i];
      #(BIT_NS);
    end
    FPGA_RX = 1'b1;
    #(BIT_NS);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] d,
                            input logic [7:0] n, input logic [7:0] tag,
                            input logic [7:0] cr, input logic [7:0] lf);
    logic [7:0] f[11];
    spi_exp_t   e;
    int         nb;
    f = '{8'h55, 8'h5D, cmd, d[31:24], d[23:16], d[15:8], d[7:0],
          n, tag, cr, lf};
    if (cr == 8'h0D && lf == 8'h0A) begin
      exp_led0 = ~exp_led0;
      if (cmd == 8'h01) begin
        nb  = (n == 0 || n > 4) ? 4 : int'(n);
        e.w = d >> (32 - 8 * nb);
        e.n = 8 * nb;
        spi_q.push_back(e);
      end
`ifdef UART_ACK_EN
      ack_q.push_back(8'h55);
      ack_q.push_back(8'h5D);
      ack_q.push_back(cmd);
      ack_q.push_back((cmd == 8'h01 || cmd == 8'hAA) ? 8'h00 : 8'h01);
      ack_q.push_back(tag);
      ack_q.push_back(8'h0D);
      ack_q.push_back(8'h0A);
`endif
    end
    @(negedge clk);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((spi_q.size() + ack_q.size()) != 0 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    repeat (80) @(posedge clk);
    @(negedge clk);
    check(tag, spi_q.size() + ack_q.size(), 0);
    check({tag, "_led"}, led, {1'b0, exp_led0});
  endtask

  int base;

  initial begin
    logic [7:0] cmds[3];
    cmds = '{8'h01, 8'hAA, 8'h4A};
    #5 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_tx", FPGA_TX, 1);
    check("rst_sck", spi_clk_rffe, 0);
    check("rst_sdo", spi_sdo_rffe, 0);
    check("rst_le", spi_le_rffe, 0);
    check("rst_led", led, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    base = sck_rises;
    send_frame(8'h01, 32'h2AFC0000, 8'h01, 8'h02, 8'h0D, 8'h0A);
    drain("wr8");
    check("wr8_sck", sck_rises - base, 8);

    base = sck_rises;
    send_frame(8'h01, 32'h12345678, 8'h00, 8'h07, 8'h0D, 8'h0A);
    drain("wr_n0");
    check("wr_n0_sck", sck_rises - base, 32);

    base = sck_rises;
    send_frame(8'hAA, 32'h0, 8'h01, 8'hAA, 8'h0D, 8'h0A);
    drain("ping");
    check("ping_sck", sck_rises - base, 0);

    base = sck_rises;
    send_frame(8'h4A, 32'h11223344, 8'h02, 8'h33, 8'h0D, 8'h0A);
    drain("badcmd");
    check("badcmd_sck", sck_rises - base, 0);

    base = sck_rises;
    send_frame(8'h01, 32'hDEADBEEF, 8'h04, 8'h55, 8'h0D, 8'h0B);
    drain("badtrl");
    check("badtrl_sck", sck_rises - base, 0);

    @(negedge clk);
    FPGA_RX = 1'b0;
    #100 FPGA_RX = 1'b1;
    #(BIT_NS * 2);

    base = sck_rises;
    send_frame(8'h01, 32'hA55A0000, 8'h02, 8'h44, 8'h0D, 8'h0A);
    drain("wr16");
    check("wr16_sck", sck_rises - base, 16);

    base = sck_rises;
    send_frame(8'h01, 32'hCAFEF00D, 8'h07, 8'h45, 8'h0D, 8'h0A);
    drain("wr_n7");
    check("wr_n7_sck", sck_rises - base, 32);

    base = sck_rises;
    send_frame(8'h01, 32'h5A5A5A5A, 8'h04, 8'h66, 8'h0D, 8'h0A);
    for (int k = 0; k < 5000 && (sck_rises - base) < 5; k++)
      @(posedge clk);
    check("mid_reached", sck_rises - base, 5);
    #30 rst_n = 1'b0;
    #1;
    check("mid_rst_sck", spi_clk_rffe, 0);
    check("mid_rst_sdo", spi_sdo_rffe, 0);
    check("mid_rst_le", spi_le_rffe, 0);
    check("mid_rst_led", led, 0);
    check("mid_rst_tx", FPGA_TX, 1);
    spi_q.delete();
    ack_q.delete();
    exp_led0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    base = sck_rises;
    send_frame(8'h01, 32'h13579BDF, 8'h03, 8'h09, 8'h0D, 8'h0A);
    drain("post_rst");
    check("post_rst_sck", sck_rises - base, 24);

    for (int r = 0; r < 2; r++) begin
      send_frame(cmds[$urandom_range(0, 2)], $urandom,
                 8'($urandom_range(0, 6)), 8'($urandom), 8'h0D, 8'h0A);
      drain("rand");
    end

`ifndef UART_ACK_EN
    check("tx_tied_high", tx_low_n, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
